// File: rtl/rsa_pkg.sv
// ---------------------------------------------------------------------------
// rsa_pkg
// Shared definitions for the modular-exponentiation sequencer:
//   - DEFAULT_WIDTH : default exponent bit count (256)
//   - state_t / ST_*: sequencer state encoding
//   - ma_op_t / MA_*: Montgomery multiplier operation codes
// ---------------------------------------------------------------------------
package rsa_pkg;

    localparam int DEFAULT_WIDTH = 256;

    // Sequencer states. The encoding is kept as fixed constants so that
    // other tools that decode the state number see the same values.
    typedef logic [3:0] state_t;
    localparam state_t ST_IDLE      = 4'd0;
    localparam state_t ST_PRE_ISS   = 4'd1;
    localparam state_t ST_PRE_WAIT  = 4'd2;
    localparam state_t ST_BIT       = 4'd3;
    localparam state_t ST_MUL_ISS   = 4'd4;
    localparam state_t ST_MUL_WAIT  = 4'd5;
    localparam state_t ST_SQR_ISS   = 4'd6;
    localparam state_t ST_SQR_WAIT  = 4'd7;
    localparam state_t ST_POST_ISS  = 4'd8;
    localparam state_t ST_POST_WAIT = 4'd9;
    localparam state_t ST_DONE      = 4'd10;

    // Montgomery multiplier operations.
    //   MUL : U <- MA(U, T)
    //   SQR : T <- MA(T, T)
    //   POST: U <- MA(U, 1)   (leave the Montgomery domain)
    typedef logic [1:0] ma_op_t;
    localparam ma_op_t MA_MUL  = 2'd0;
    localparam ma_op_t MA_SQR  = 2'd1;
    localparam ma_op_t MA_POST = 2'd2;

endpackage : rsa_pkg

// File: rtl/rsa_exp_ctrl.sv
// ---------------------------------------------------------------------------
// rsa_exp_ctrl
// Sequencer for right-to-left binary modular exponentiation in the
// Montgomery domain: one pre-modulo step, then for each exponent bit an
// optional multiply followed by a square (no square after the last bit),
// then one conversion out of the Montgomery domain.
//
// Parameters
//   WIDTH  exponent bit count (>= 2)
//   CNT_W  bit-index width, equal to clog2(WIDTH)
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   start      launch request, sampled only while idle
//   ready      high while idle
//   done       one-cycle completion pulse
//   exp_idx    exponent bit index currently being processed
//   exp_bit    exponent bit at exp_idx (combinational from register file)
//   u_init     one-cycle pulse: load U with Montgomery one
//   pre_start  one-cycle pulse: start pre-modulo T = base*2^WIDTH mod N
//   pre_done   pre-modulo complete (level or pulse)
//   ma_start   one-cycle pulse: launch Montgomery multiplier
//   ma_op      multiplier operation, stable from ma_start to ma_done
//   ma_done    multiplier complete (level or pulse)
//
// Every output is a decode of registered state; no input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module rsa_exp_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             ready,
    output logic             done,
    output logic [CNT_W-1:0] exp_idx,
    input  logic             exp_bit,
    output logic             u_init,
    output logic             pre_start,
    input  logic             pre_done,
    output logic             ma_start,
    output logic [1:0]       ma_op,
    input  logic             ma_done
);

    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] k_reg, k_next;
    ma_op_t           op_reg, op_next;
    logic             last_bit;

    assign last_bit = (k_reg == K_LAST);

    // -----------------------------------------------------------------------
    // Next-state, bit counter and operation register.
    // op_reg is only loaded on the transition into an ISS state, so the
    // multiplier sees a constant operation for the whole launch/wait window.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        op_next    = op_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    k_next     = '0;
                    state_next = ST_PRE_ISS;
                end
            end

            ST_PRE_ISS: state_next = ST_PRE_WAIT;

            ST_PRE_WAIT: begin
                if (pre_done) begin
                    state_next = ST_BIT;
                end
            end

            // Decision cycle: multiply if the bit is set, otherwise go
            // straight to the square, or finish when this was the last bit.
            ST_BIT: begin
                if (exp_bit) begin
                    state_next = ST_MUL_ISS;
                    op_next    = MA_MUL;
                end else if (!last_bit) begin
                    state_next = ST_SQR_ISS;
                    op_next    = MA_SQR;
                end else begin
                    state_next = ST_POST_ISS;
                    op_next    = MA_POST;
                end
            end

            ST_MUL_ISS: state_next = ST_MUL_WAIT;

            // The square following the last bit would be wasted work,
            // so the last multiply goes directly to the post conversion.
            ST_MUL_WAIT: begin
                if (ma_done) begin
                    if (!last_bit) begin
                        state_next = ST_SQR_ISS;
                        op_next    = MA_SQR;
                    end else begin
                        state_next = ST_POST_ISS;
                        op_next    = MA_POST;
                    end
                end
            end

            ST_SQR_ISS: state_next = ST_SQR_WAIT;

            // A square is never issued at the last bit, so this increment
            // cannot carry past WIDTH-1.
            ST_SQR_WAIT: begin
                if (ma_done) begin
                    k_next     = k_reg + CNT_W'(1);
                    state_next = ST_BIT;
                end
            end

            ST_POST_ISS: state_next = ST_POST_WAIT;

            ST_POST_WAIT: begin
                if (ma_done) begin
                    state_next = ST_DONE;
                end
            end

            ST_DONE: state_next = ST_IDLE;

            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            k_reg     <= '0;
            op_reg    <= MA_MUL;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            op_reg    <= op_next;
        end
    end

    // -----------------------------------------------------------------------
    // Output decodes
    // -----------------------------------------------------------------------
    assign ready     = (state_reg == ST_IDLE);
    assign done      = (state_reg == ST_DONE);
    assign u_init    = (state_reg == ST_PRE_ISS);
    assign pre_start = (state_reg == ST_PRE_ISS);
    assign ma_start  = (state_reg == ST_MUL_ISS) ||
                       (state_reg == ST_SQR_ISS) ||
                       (state_reg == ST_POST_ISS);
    assign ma_op     = op_reg;
    assign exp_idx   = k_reg;

endmodule : rsa_exp_ctrl

// File: tb/tb_rsa_exp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rsa_exp_ctrl
// Directed bench for rsa_exp_ctrl at WIDTH=4 and WIDTH=256. The expected
// multiplier operation sequence (op and bit index) is derived from the
// exponent and queued before each run; each ma_start pops and compares.
// ---------------------------------------------------------------------------
module tb_rsa_exp_ctrl;
    import rsa_pkg::*;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] k;
    } exp_op_t;

    logic clk;
    logic rst_n;

    // WIDTH=4 instance
    logic       start4, ready4, done4, u_init4, pre_start4, pre_done4;
    logic       ma_start4, ma_done4, exp_bit4;
    logic [1:0] exp_idx4, ma_op4;
    logic [3:0] e4;

    // WIDTH=256 instance
    logic         start256, ready256, done256, u_init256, pre_start256, pre_done256;
    logic         ma_start256, ma_done256, exp_bit256;
    logic [7:0]   exp_idx256;
    logic [1:0]   ma_op256;
    logic [255:0] e256;

    exp_op_t op_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    assign exp_bit4   = e4[exp_idx4];
    assign exp_bit256 = e256[exp_idx256];

    rsa_exp_ctrl #(.WIDTH(4), .CNT_W(2)) dut4 (
        .clk(clk), .reset(rst_n), .start(start4), .ready(ready4), .done(done4),
        .exp_idx(exp_idx4), .exp_bit(exp_bit4), .u_init(u_init4),
        .pre_start(pre_start4), .pre_done(pre_done4), .ma_start(ma_start4),
        .ma_op(ma_op4), .ma_done(ma_done4)
    );

    rsa_exp_ctrl #(.WIDTH(256), .CNT_W(8)) dut256 (
        .clk(clk), .reset(rst_n), .start(start256), .ready(ready256), .done(done256),
        .exp_idx(exp_idx256), .exp_bit(exp_bit256), .u_init(u_init256),
        .pre_start(pre_start256), .pre_done(pre_done256), .ma_start(ma_start256),
        .ma_op(ma_op256), .ma_done(ma_done256)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic exp_op_t mk(input logic [1:0] op, input int k);
        exp_op_t x;
        x.op = op;
        x.k  = 8'(k);
        return x;
    endfunction

    task automatic chk_rst4(input string tag);
        chk({tag, "_ready"},     ready4,     1);
        chk({tag, "_done"},      done4,      0);
        chk({tag, "_exp_idx"},   exp_idx4,   0);
        chk({tag, "_u_init"},    u_init4,    0);
        chk({tag, "_pre_start"}, pre_start4, 0);
        chk({tag, "_ma_start"},  ma_start4,  0);
        chk({tag, "_ma_op"},     ma_op4,     0);
    endtask

    // One WIDTH=4 run. pdly/mdly: extra wait cycles before pre_done/ma_done.
    // stray: inject ignored start/ma_done pulses. abort_k: reset in SQR_WAIT
    // at that index (-1 = never). hold: keep start high to check relaunch.
    task automatic run4(input logic [3:0] e, input int pdly, input int mdly,
                        input bit stray, input int abort_k, input bit hold);
        int cyc, pc, exp_lat, done_at, pre_due, ma_due, issue_cyc;
        int nmul, nsqr, npost, npre, nui;
        bit in_ma, aborted;
        logic [1:0] cur_op;
        exp_op_t x;

        op_q.delete();
        pc = 0;
        for (int k = 0; k < 4; k++) begin
            if (e[k]) begin
                op_q.push_back(mk(MA_MUL, k));
                pc++;
            end
            if (k < 3) op_q.push_back(mk(MA_SQR, k));
        end
        op_q.push_back(mk(MA_POST, 3));
        exp_lat = 3 + 3 * 3 + 2 * pc + 2 + 1 + pdly + mdly * (3 + pc + 1);

        e4 = e;
        @(negedge clk);
        chk("ready_idle", ready4, 1);
        start4 = 1'b1;
        cyc = 0; done_at = -1; pre_due = -1; ma_due = -1; issue_cyc = -1;
        nmul = 0; nsqr = 0; npost = 0; npre = 0; nui = 0;
        in_ma = 1'b0; aborted = 1'b0; cur_op = MA_MUL;

        while (cyc < 400) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (!hold) start4 = 1'b0;
            pre_done4 = 1'b0;
            ma_done4  = 1'b0;

            if (done_at < 0) begin
                if (cyc == 1) chk("ready_low", ready4, 0);
                if (pre_start4) begin
                    npre++;
                    chk("pre_start_cyc", cyc, 1);
                    pre_due = cyc + 1 + pdly;
                end
                if (u_init4) begin
                    nui++;
                    chk("u_init_cyc", cyc, 1);
                end
                if (cyc == pre_due) pre_done4 = 1'b1;
                if (stray && cyc == 2) begin
                    start4   = 1'b1;
                    ma_done4 = 1'b1;
                end
                if (ma_start4) begin
                    chk("q_nonempty", op_q.size() > 0, 1);
                    if (op_q.size() > 0) begin
                        x = op_q.pop_front();
                        chk("ma_op", ma_op4, x.op);
                        chk("exp_idx", exp_idx4, x.k);
                    end
                    $display("w4 cyc %0d: ma_start op=%0d k=%0d", cyc, ma_op4, exp_idx4);
                    if (ma_op4 == MA_MUL)  nmul++;
                    if (ma_op4 == MA_SQR)  nsqr++;
                    if (ma_op4 == MA_POST) npost++;
                    cur_op    = ma_op4;
                    in_ma     = 1'b1;
                    issue_cyc = cyc;
                    ma_due    = cyc + 1 + mdly;
                    if (stray) ma_done4 = 1'b1;
                end else if (in_ma) begin
                    chk("ma_op_hold", ma_op4, cur_op);
                    if (stray && cur_op == MA_MUL && cyc == issue_cyc + 1) start4 = 1'b1;
                    if (abort_k >= 0 && cur_op == MA_SQR && int'(exp_idx4) == abort_k) begin
                        rst_n = 1'b0;
                        #1;
                        $display("w4 cyc %0d: reset asserted in SQR_WAIT k=%0d", cyc, abort_k);
                        chk_rst4("abort");
                        @(negedge clk);
                        rst_n   = 1'b1;
                        aborted = 1'b1;
                        break;
                    end
                    if (cyc == ma_due) begin
                        ma_done4 = 1'b1;
                        in_ma    = 1'b0;
                    end
                end
                if (done4) begin
                    done_at = cyc;
                    $display("w4 cyc %0d: done", cyc);
                    chk("done_cyc", cyc, exp_lat);
                end
            end else if (cyc == done_at + 1) begin
                chk("ready_after_done", ready4, 1);
                chk("done_pulse_end", done4, 0);
                if (!hold) break;
            end else begin
                chk("relaunch_pre_start", pre_start4, 1);
                break;
            end
        end
        start4    = 1'b0;
        pre_done4 = 1'b0;
        ma_done4  = 1'b0;

        if (!aborted) begin
            chk("done_seen", done_at >= 0, 1);
            chk("mul_count",  nmul,  pc);
            chk("sqr_count",  nsqr,  3);
            chk("post_count", npost, 1);
            chk("pre_count",  npre,  1);
            chk("uinit_count", nui,  1);
            chk("q_drained", op_q.size(), 0);
        end
    endtask

    task automatic run256();
        logic [255:0] e;
        int cyc, pc, exp_lat, done_at, pre_due, ma_due, nmul, nsqr;
        exp_op_t x;

        for (int w = 0; w < 8; w++) e[w*32 +: 32] = $urandom;
        op_q.delete();
        pc = 0;
        for (int k = 0; k < 256; k++) begin
            if (e[k]) begin
                op_q.push_back(mk(MA_MUL, k));
                pc++;
            end
            if (k < 255) op_q.push_back(mk(MA_SQR, k));
        end
        op_q.push_back(mk(MA_POST, 255));
        exp_lat = 3 + 3 * 255 + 2 * pc + 2 + 1;

        e256 = e;
        @(negedge clk);
        chk("w256_ready_idle", ready256, 1);
        start256 = 1'b1;
        cyc = 0; done_at = -1; pre_due = -1; ma_due = -1; nmul = 0; nsqr = 0;

        while (cyc < 3000 && done_at < 0) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start256    = 1'b0;
            pre_done256 = 1'b0;
            ma_done256  = 1'b0;
            if (pre_start256) pre_due = cyc + 1;
            if (cyc == pre_due) pre_done256 = 1'b1;
            if (ma_start256) begin
                chk("w256_q_nonempty", op_q.size() > 0, 1);
                if (op_q.size() > 0) begin
                    x = op_q.pop_front();
                    chk("w256_ma_op", ma_op256, x.op);
                    chk("w256_exp_idx", exp_idx256, x.k);
                end
                if (ma_op256 == MA_MUL) nmul++;
                if (ma_op256 == MA_SQR) nsqr++;
                ma_due = cyc + 1;
            end
            if (cyc == ma_due) ma_done256 = 1'b1;
            if (done256) done_at = cyc;
        end
        pre_done256 = 1'b0;
        ma_done256  = 1'b0;
        $display("w256: popcount=%0d mul=%0d sqr=%0d done at cyc %0d", pc, nmul, nsqr, done_at);
        chk("w256_done_seen", done_at >= 0, 1);
        chk("w256_done_cyc", done_at, exp_lat);
        chk("w256_mul_count", nmul, pc);
        chk("w256_sqr_count", nsqr, 255);
        chk("w256_final_idx", exp_idx256, 255);
        chk("w256_q_drained", op_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start4 = 1'b0; pre_done4 = 1'b0; ma_done4 = 1'b0; e4 = '0;
        start256 = 1'b0; pre_done256 = 1'b0; ma_done256 = 1'b0; e256 = '0;
        #1;
        chk_rst4("rst");
        chk("rst_w256_ready", ready256, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Baseline: MUL,SQR,SQR,MUL,SQR,POST; done at cycle 19
        run4(4'b0101, 0, 0, 1'b0, -1, 1'b0);
        // All-zero exponent: SQR x3 then POST
        run4(4'b0000, 0, 0, 1'b0, -1, 1'b0);
        // All ones, ma_done arriving in the fifth wait cycle
        run4(4'b1111, 0, 4, 1'b0, -1, 1'b0);
        // Stray start and done pulses must be ignored
        run4(4'b0101, 1, 1, 1'b1, -1, 1'b0);
        // start held through DONE relaunches one cycle after DONE
        run4(4'b0101, 0, 0, 1'b0, -1, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_rst4("rst2");
        @(negedge clk);
        rst_n = 1'b1;
        // Reset in SQR_WAIT at k=2, then a clean run
        run4(4'b1111, 0, 2, 1'b0, 2, 1'b0);
        run4(4'b1111, 0, 0, 1'b0, -1, 1'b0);
        // Full width, random exponent
        run256();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_rsa_exp_ctrl

// File: doc/rsa_exp_ctrl.md
# rsa_exp_ctrl

Sequencer for the 256-bit modular exponentiation datapath (result = base^exp mod N). It runs right-to-left binary exponentiation in the Montgomery domain: one pre-modulo step, then per exponent bit an optional multiply and a square, then one conversion out of the Montgomery domain. It drives the pre-modulo unit and the Montgomery multiplier through start/done handshakes and reads the exponent one bit at a time. It sits between the byte-wide host register interface (start/ready) and the arithmetic units.

## Interface
- WIDTH, 256, exponent bit count; minimum 2.
- CNT_W, 8, width of the bit index; must equal clog2(WIDTH).

- clk  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE; ignored at all other times.
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse in DONE.
- exp_idx  out  CNT_W  current exponent bit index k.
- exp_bit  in  1  exponent bit at exp_idx; combinational from the register file.
- u_init  out  1  one-cycle pulse: datapath loads U with Montgomery one.
- pre_start  out  1  one-cycle pulse: pre-modulo unit computes T = base·2^WIDTH mod N.
- pre_done  in  1  pre-modulo complete; level or pulse.
- ma_start  out  1  one-cycle pulse launching the Montgomery multiplier.
- ma_op  out  2  operation, held stable from ma_start until ma_done: 0 MUL U←MA(U,T); 1 SQR T←MA(T,T); 2 POST U←MA(U,1).
- ma_done  in  1  multiplier complete; level or pulse.

## Operation
- States: IDLE, PRE_ISS, PRE_WAIT, BIT, MUL_ISS, MUL_WAIT, SQR_ISS, SQR_WAIT, POST_ISS, POST_WAIT, DONE.
- IDLE: ready=1. If start=1, set k←0 and go to PRE_ISS.
- PRE_ISS: pre_start=1 and u_init=1 for this cycle; go to PRE_WAIT.
- PRE_WAIT: stay until pre_done=1, then go to BIT.
- BIT (decision cycle; no outputs asserted):
  - exp_bit=1 → MUL_ISS.
  - exp_bit=0 and k<WIDTH-1 → SQR_ISS.
  - exp_bit=0 and k=WIDTH-1 → POST_ISS.
- MUL_ISS: ma_start=1, ma_op=0 → MUL_WAIT. On ma_done: k<WIDTH-1 → SQR_ISS; k=WIDTH-1 → POST_ISS.
- SQR_ISS: ma_start=1, ma_op=1 → SQR_WAIT. On ma_done: k←k+1, go to BIT.
  - The square after the last bit is never issued.
- POST_ISS: ma_start=1, ma_op=2 → POST_WAIT. On ma_done → DONE.
- DONE: done=1 for one cycle → IDLE.
- Op count: SQR issued exactly WIDTH-1 times; MUL issued popcount(exp) times; POST issued once.
- Done inputs are honoured only in their own WAIT state. pre_done or ma_done seen in any other state (including ISS cycles) is ignored.
- k: increments only on leaving SQR_WAIT and never exceeds WIDTH-1, so there is no wrap. exp_idx = k at all times.

## Timing
- Reset values (asynchronous, take effect immediately): state IDLE, ready=1, done=0, exp_idx=0, u_init=0, pre_start=0, ma_start=0, ma_op=0.
- Reset asserted mid-operation aborts the operation. Outstanding datapath operations are abandoned; the datapath is reset by the same signal.
- All outputs are registered-state decodes with no combinational path from any input to any output. ma_op changes only on entry to an ISS state.
- ready falls in the cycle after start is sampled. ready rises in the cycle after DONE.
- Minimum latency is with pre_done and ma_done high in the first WAIT cycle:
  - Cycles from start sample to done = 3 + 3·(WIDTH-1) + 2·popcount(exp) + 2 + 1, counting the start-sample cycle as 0.
  - Each extra datapath wait cycle adds one cycle.
- start held high through DONE re-launches: IDLE samples it one cycle after DONE.

## Structure
- Package rsa_pkg: state enum, ma_op codes (MA_MUL=0, MA_SQR=1, MA_POST=2), default WIDTH.
- Single module, no sub-modules. Next-state logic and bit counter live in one FSM; its RTL target is 150–250 lines.

## Test plan
- WIDTH=4, exp=4'b0101, immediate dones, start at cycle 0 → op sequence MUL,SQR,SQR,MUL,SQR,POST; done=1 at cycle 19; ready=1 at cycle 20; exactly 6 ma_start pulses.
- WIDTH=4, exp=0 → SQR×3 then POST; no MUL; u_init and pre_start each pulse exactly once, at cycle 1.
- WIDTH=4, exp=4'b1111, ma_done delayed 5 cycles per op → 4 MUL, 3 SQR, 1 POST; ma_op stable across every wait; minimum latency plus 8×4 cycles.
- start pulsed during PRE_WAIT and MUL_WAIT, plus stray ma_done in PRE_WAIT and in ISS cycles → no restart, no state advance, sequence identical to baseline.
- reset driven low in SQR_WAIT at k=2 → outputs immediately at reset values; after release, a new start runs a full, correct sequence from k=0.
- WIDTH=256, random exp → MUL count = popcount(exp), SQR count = 255; exp_idx sweeps 0..255 monotonically.
